// File: rtl/elevator_pkg.sv
// Shared elevator types: door FSM state encoding, default tick counts and
// the timer width helper used by the door controller.
package elevator_pkg;

    typedef enum logic [2:0] {
        CLOSED   = 3'd0,
        OPENING  = 3'd1,
        OPEN     = 3'd2,
        OVERLOAD = 3'd3,
        CLOSING  = 3'd4
    } door_state_t;

    localparam int DEF_MOVE_TICKS  = 3;
    localparam int DEF_DWELL_TICKS = 5;

    // Width of a down-counter able to hold N-1 for the larger of the two
    // phase lengths; never narrower than one bit.
    function automatic int timer_width(input int move_ticks, input int dwell_ticks);
        int max_ticks;
        int w;
        max_ticks = (move_ticks > dwell_ticks) ? move_ticks : dwell_ticks;
        w = $clog2(max_ticks);
        return (w < 1) ? 1 : w;
    endfunction

    // Door is fully open (and passenger counting allowed) in these states.
    function automatic logic door_level(input door_state_t st);
        return (st == OPEN) || (st == OVERLOAD);
    endfunction

endpackage

// File: rtl/door_controller_if.sv
// Signal bundle between the cabin/weight side and the door controller.
// The master drives requests and sensor levels; the slave (controller)
// drives door level, alarm, interlock and debug state.
interface door_controller_if;
    logic       arrive;
    logic       door_open_btn;
    logic       door_close_btn;
    logic       obstruction;
    logic       weight_limit_exceeded;
    logic       weight_recount;
    logic       door;
    logic       weight_flip_reset;
    logic       buzzer;
    logic       car_ready;
    logic [2:0] state_o;

    modport master (
        output arrive,
        output door_open_btn,
        output door_close_btn,
        output obstruction,
        output weight_limit_exceeded,
        output weight_recount,
        input  door,
        input  weight_flip_reset,
        input  buzzer,
        input  car_ready,
        input  state_o
    );

    modport slave (
        input  arrive,
        input  door_open_btn,
        input  door_close_btn,
        input  obstruction,
        input  weight_limit_exceeded,
        input  weight_recount,
        output door,
        output weight_flip_reset,
        output buzzer,
        output car_ready,
        output state_o
    );
endinterface

// File: rtl/door_controller_timer.sv
// Loadable saturating down-counter: load has priority, otherwise it
// decrements while enabled and holds at zero instead of wrapping.
module door_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_r;

    // Counter register: load, saturating decrement, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/door_controller.sv
// Car door controller: sequences open/dwell/close, reopens on obstruction,
// holds the door open with an alarm while overloaded, pulses the weight
// counter clear when an overload is resolved by recount, and grants motion
// only with the door closed and the load within limit.
module door_controller
    import elevator_pkg::*;
#(
    parameter int MOVE_TICKS  = DEF_MOVE_TICKS,
    parameter int DWELL_TICKS = DEF_DWELL_TICKS
) (
    input  logic              clk,
    input  logic              button_reset,
    door_controller_if.slave  bus
);

    localparam int TW = timer_width(MOVE_TICKS, DWELL_TICKS);
    localparam logic [TW-1:0] MOVE_LOAD  = TW'(MOVE_TICKS - 1);
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_TICKS - 1);

    door_state_t   state_r;
    door_state_t   state_next_s;
    logic          load_s;
    logic [TW-1:0] load_val_s;
    logic          en_s;
    logic          zero_s;
    logic          flip_next_s;
    logic          door_r;
    logic          buzzer_r;
    logic          flip_r;

    door_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (button_reset),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (en_s),
        .zero     (zero_s)
    );

    // Next-state and timer control; every phase change reloads the timer.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_val_s   = '0;
        en_s         = 1'b0;
        flip_next_s  = 1'b0;
        case (state_r)
            CLOSED: begin
                if (bus.arrive || bus.door_open_btn) begin
                    state_next_s = OPENING;
                    load_s       = 1'b1;
                    load_val_s   = MOVE_LOAD;
                end else begin
                    state_next_s = CLOSED;
                end
            end
            OPENING: begin
                if (zero_s) begin
                    state_next_s = OPEN;
                    load_s       = 1'b1;
                    load_val_s   = DWELL_LOAD;
                end else begin
                    en_s = 1'b1;
                end
            end
            OPEN: begin
                if (bus.weight_limit_exceeded) begin
                    state_next_s = OVERLOAD;
                end else if (bus.door_open_btn) begin
                    load_s     = 1'b1;
                    load_val_s = DWELL_LOAD;
                end else if (bus.door_close_btn || zero_s) begin
                    state_next_s = CLOSING;
                    load_s       = 1'b1;
                    load_val_s   = MOVE_LOAD;
                end else begin
                    en_s = 1'b1;
                end
            end
            OVERLOAD: begin
                // Recount takes precedence so the weight counter is cleared
                // even when the flag drops in the same cycle.
                if (bus.weight_recount) begin
                    state_next_s = OPEN;
                    load_s       = 1'b1;
                    load_val_s   = DWELL_LOAD;
                    flip_next_s  = 1'b1;
                end else if (!bus.weight_limit_exceeded) begin
                    state_next_s = OPEN;
                    load_s       = 1'b1;
                    load_val_s   = DWELL_LOAD;
                end else begin
                    state_next_s = OVERLOAD;
                end
            end
            CLOSING: begin
                if (bus.obstruction || bus.door_open_btn || bus.weight_limit_exceeded) begin
                    state_next_s = OPENING;
                    load_s       = 1'b1;
                    load_val_s   = MOVE_LOAD;
                end else if (zero_s) begin
                    state_next_s = CLOSED;
                end else begin
                    en_s = 1'b1;
                end
            end
            default: begin
                state_next_s = CLOSED;
            end
        endcase
    end

    // State register plus registered output decodes aligned with the state.
    always_ff @(posedge clk or negedge button_reset) begin
        if (!button_reset) begin
            state_r  <= CLOSED;
            door_r   <= 1'b0;
            buzzer_r <= 1'b0;
            flip_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            door_r   <= door_level(state_next_s);
            buzzer_r <= (state_next_s == OVERLOAD);
            flip_r   <= flip_next_s;
        end
    end

    assign bus.door              = door_r;
    assign bus.buzzer            = buzzer_r;
    assign bus.weight_flip_reset = flip_r;
    assign bus.state_o           = state_r;
    assign bus.car_ready         = (state_r == CLOSED) && !bus.weight_limit_exceeded;

endmodule

// File: tb/tb_door_controller.sv
// Self-checking bench for door_controller: directed scenarios followed by
// randomized traffic, all checked against a phase/cycles-remaining model.
module tb_door_controller;

    localparam int MOVE  = 3;
    localparam int DWELL = 5;

    logic clk = 1'b0;
    logic button_reset;

    always #5 clk = ~clk;

    door_controller_if bus();

    door_controller #(.MOVE_TICKS(MOVE), .DWELL_TICKS(DWELL)) dut (
        .clk          (clk),
        .button_reset (button_reset),
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase number (0 closed, 1 opening, 2 open,
    // 3 overload, 4 closing) and cycles still to spend in that phase.
    int m_phase = 0;
    int m_left  = 0;
    bit m_pulse = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step();
        m_pulse = 1'b0;
        case (m_phase)
            0: if (bus.arrive || bus.door_open_btn) begin m_phase = 1; m_left = MOVE; end
            1: if (m_left == 1) begin m_phase = 2; m_left = DWELL; end else m_left--;
            2: begin
                if (bus.weight_limit_exceeded) m_phase = 3;
                else if (bus.door_open_btn) m_left = DWELL;
                else if (bus.door_close_btn || m_left == 1) begin m_phase = 4; m_left = MOVE; end
                else m_left--;
            end
            3: begin
                if (bus.weight_recount) begin m_phase = 2; m_left = DWELL; m_pulse = 1'b1; end
                else if (!bus.weight_limit_exceeded) begin m_phase = 2; m_left = DWELL; end
            end
            4: begin
                if (bus.obstruction || bus.door_open_btn || bus.weight_limit_exceeded) begin
                    m_phase = 1; m_left = MOVE;
                end else if (m_left == 1) m_phase = 0;
                else m_left--;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(bus.state_o), 32'(m_phase));
        chk({tag, ".door"},   32'(bus.door), 32'((m_phase == 2) || (m_phase == 3)));
        chk({tag, ".buzzer"}, 32'(bus.buzzer), 32'(m_phase == 3));
        chk({tag, ".flip"},   32'(bus.weight_flip_reset), 32'(m_pulse));
        chk({tag, ".ready"},  32'(bus.car_ready),
            32'((m_phase == 0) && !bus.weight_limit_exceeded));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic set_in(input logic a, input logic o, input logic c,
                          input logic ob, input logic w, input logic r);
        bus.arrive                = a;
        bus.door_open_btn         = o;
        bus.door_close_btn        = c;
        bus.obstruction           = ob;
        bus.weight_limit_exceeded = w;
        bus.weight_recount        = r;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        button_reset = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst.state",  32'(bus.state_o), 32'd0);
        chk("rst.door",   32'(bus.door), 32'd0);
        chk("rst.buzzer", 32'(bus.buzzer), 32'd0);
        chk("rst.flip",   32'(bus.weight_flip_reset), 32'd0);
        chk("rst.ready",  32'(bus.car_ready), 32'd1);
        model_reset();
        @(negedge clk);
        button_reset = 1'b1;
        tick("rst_rel");

        // Normal stop
        bus.arrive = 1'b1;
        tick("norm_arr");
        bus.arrive = 1'b0;
        ticks(2, "norm_opening");
        chk("norm.opening_end", 32'(bus.state_o), 32'd1);
        tick("norm_open1");
        chk("norm.open_entry", 32'(bus.door), 32'd1);
        ticks(5, "norm_open");
        chk("norm.closing", 32'(bus.state_o), 32'd4);
        ticks(3, "norm_closing");
        chk("norm.closed", 32'(bus.state_o), 32'd0);
        chk("norm.ready", 32'(bus.car_ready), 32'd1);

        // Overload hold and recount exit
        bus.arrive = 1'b1;
        tick("ovl_arr");
        bus.arrive = 1'b0;
        ticks(3, "ovl_opening");
        bus.weight_limit_exceeded = 1'b1;
        tick("ovl_enter");
        chk("ovl.state", 32'(bus.state_o), 32'd3);
        chk("ovl.buzzer", 32'(bus.buzzer), 32'd1);
        ticks(10, "ovl_hold");
        bus.door_close_btn = 1'b1;
        ticks(10, "ovl_close");
        chk("ovl.still", 32'(bus.state_o), 32'd3);
        bus.door_close_btn = 1'b0;
        bus.weight_recount = 1'b1;
        bus.weight_limit_exceeded = 1'b0;
        tick("ovl_recount");
        chk("ovl.pulse", 32'(bus.weight_flip_reset), 32'd1);
        chk("ovl.reopen", 32'(bus.state_o), 32'd2);
        bus.weight_recount = 1'b0;
        tick("ovl_after");
        chk("ovl.pulse_once", 32'(bus.weight_flip_reset), 32'd0);
        ticks(4, "ovl_dwell");
        chk("ovl.closing", 32'(bus.state_o), 32'd4);
        ticks(3, "ovl_close_out");

        // Reversal on obstruction, then on open button
        bus.arrive = 1'b1;
        tick("rev_arr");
        bus.arrive = 1'b0;
        ticks(8, "rev_run");
        tick("rev_closing2");
        bus.obstruction = 1'b1;
        tick("rev_obs");
        chk("rev.obs_opening", 32'(bus.state_o), 32'd1);
        bus.obstruction = 1'b0;
        ticks(3, "rev_reopen");
        chk("rev.open", 32'(bus.state_o), 32'd2);
        ticks(5, "rev_dwell");
        bus.door_open_btn = 1'b1;
        tick("rev_btn");
        chk("rev.btn_opening", 32'(bus.state_o), 32'd1);
        bus.door_open_btn = 1'b0;
        ticks(11, "rev_out");
        chk("rev.closed", 32'(bus.state_o), 32'd0);

        // Open button held, open+close together, close on first open cycle
        bus.arrive = 1'b1;
        tick("btn_arr");
        bus.arrive = 1'b0;
        ticks(3, "btn_opening");
        bus.door_open_btn = 1'b1;
        ticks(12, "btn_hold");
        chk("btn.held_open", 32'(bus.state_o), 32'd2);
        bus.door_open_btn = 1'b0;
        ticks(4, "btn_dwell");
        chk("btn.dwell_open", 32'(bus.state_o), 32'd2);
        tick("btn_dwell_end");
        chk("btn.closing", 32'(bus.state_o), 32'd4);
        ticks(3, "btn_close_out");
        bus.arrive = 1'b1;
        tick("both_arr");
        bus.arrive = 1'b0;
        ticks(3, "both_opening");
        bus.door_open_btn = 1'b1;
        bus.door_close_btn = 1'b1;
        ticks(4, "both_hold");
        chk("both.open", 32'(bus.state_o), 32'd2);
        bus.door_open_btn = 1'b0;
        bus.door_close_btn = 1'b0;
        ticks(8, "both_out");
        bus.arrive = 1'b1;
        tick("cls_arr");
        bus.arrive = 1'b0;
        ticks(3, "cls_opening");
        bus.door_close_btn = 1'b1;
        tick("cls_press");
        chk("cls.closing", 32'(bus.state_o), 32'd4);
        bus.door_close_btn = 1'b0;
        ticks(3, "cls_out");

        // Interlocks
        bus.weight_limit_exceeded = 1'b1;
        tick("lock_wle");
        chk("lock.state", 32'(bus.state_o), 32'd0);
        chk("lock.ready", 32'(bus.car_ready), 32'd0);
        bus.weight_limit_exceeded = 1'b0;
        tick("lock_clear");
        bus.arrive = 1'b1;
        tick("ign_arr");
        bus.arrive = 1'b0;
        ticks(3, "ign_opening");
        bus.arrive = 1'b1;
        tick("ign_arrive_open");
        chk("ign.open", 32'(bus.state_o), 32'd2);
        bus.arrive = 1'b0;
        ticks(7, "ign_out");
        bus.arrive = 1'b1;
        tick("ar_arr");
        bus.arrive = 1'b0;
        #2;
        button_reset = 1'b0;
        #1;
        chk("ar.state", 32'(bus.state_o), 32'd0);
        chk("ar.door", 32'(bus.door), 32'd0);
        chk("ar.flip", 32'(bus.weight_flip_reset), 32'd0);
        model_reset();
        @(negedge clk);
        button_reset = 1'b1;
        tick("ar_release");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.arrive         = ($urandom % 8) == 0;
            bus.door_open_btn  = ($urandom % 7) == 0;
            bus.door_close_btn = ($urandom % 5) == 0;
            bus.obstruction    = ($urandom % 9) == 0;
            bus.weight_recount = ($urandom % 6) == 0;
            if (($urandom % 10) == 0) bus.weight_limit_exceeded = ~bus.weight_limit_exceeded;
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
